// File: rtl/rv32_store_align.sv
// Store formatter: turns SB/SH/SW requests into word-aligned, lane-shifted, strobed beats behind an in-order FIFO.
// Optional macro RV32_STORE_SPLIT_EN: split word-crossing stores into two beats instead of faulting.
package rv32_store_align_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wbeat_t;
endpackage

module rv32_store_align
  import rv32_store_align_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  mem_op_t                    req_op,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       misalign_valid,
  output logic [31:0]                misalign_addr,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RV32_STORE_SPLIT_EN
  localparam int SW_W = 64;
  // Two free slots are needed so a split store can push both beats at once.
  localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);
`else
  localparam int SW_W = 32;
  localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 1);
`endif

  logic [1:0]        off;
  logic              is_store;
  logic              misaligned;
  logic [3:0]        mask;
  logic [SW_W-1:0]   data_sh;
  logic [SW_W/8-1:0] strb_sh;
  logic              accept;
  logic              pop;
  logic [1:0]        n_push;
  logic              fault;
  wbeat_t            beat0;

  wbeat_t            fifo_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic              fault_q;
  logic [31:0]       fault_addr_q;

  assign off = req_addr[1:0];

  always_comb begin
    is_store = 1'b1;
    mask     = 4'b0000;
    case (req_op)
      MEM_SB:  mask = 4'b0001;
      MEM_SH:  mask = 4'b0011;
      MEM_SW:  mask = 4'b1111;
      default: is_store = 1'b0;
    endcase
  end

  assign misaligned = (req_op == MEM_SH && off[0]) || (req_op == MEM_SW && off != 2'd0);

  // Shift through a double-width window: low word is beat0, high word is the spill into beat1.
  assign data_sh = {{(SW_W-32){1'b0}}, req_data} << {off, 3'b000};
  assign strb_sh = {{(SW_W/8-4){1'b0}}, mask} << off;

  assign beat0 = '{addr: {req_addr[31:2], 2'b00}, wdata: data_sh[31:0], wstrb: strb_sh[3:0]};

  assign accept = req_valid && req_ready;
  assign pop    = mem_valid && mem_ready;

`ifdef RV32_STORE_SPLIT_EN
  wbeat_t beat1;
  logic   crosses;

  assign beat1   = '{addr: beat0.addr + 32'd4, wdata: data_sh[63:32], wstrb: strb_sh[7:4]};
  assign crosses = strb_sh[7:4] != 4'b0000;
  assign fault   = 1'b0;

  always_comb begin
    n_push = 2'd0;
    if (accept && is_store) n_push = crosses ? 2'd2 : 2'd1;
  end
`else
  assign fault  = accept && misaligned;
  assign n_push = (accept && is_store && !misaligned) ? 2'd1 : 2'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      if (n_push != 2'd0) fifo_q[wptr_q] <= beat0;
`ifdef RV32_STORE_SPLIT_EN
      if (n_push == 2'd2) fifo_q[wptr_q + AW'(1)] <= beat1;
`endif
      wptr_q  <= wptr_q + AW'(n_push);
      rptr_q  <= rptr_q + AW'(pop);
      count_q <= count_q + CW'(n_push) - CW'(pop);
      fault_q <= fault;
      if (fault) fault_addr_q <= req_addr;
    end
  end

  assign count          = count_q;
  assign req_ready      = count_q <= RDY_MAX;
  assign mem_valid      = count_q != '0;
  assign mem_addr       = mem_valid ? fifo_q[rptr_q].addr  : '0;
  assign mem_wdata      = mem_valid ? fifo_q[rptr_q].wdata : '0;
  assign mem_wstrb      = mem_valid ? fifo_q[rptr_q].wstrb : '0;
  assign misalign_valid = fault_q;
  assign misalign_addr  = fault_addr_q;
endmodule

// File: tb/tb_rv32_store_align.sv
// Directed bench for rv32_store_align: formatting, faults/splits, backpressure, async reset.
module tb_rv32_store_align;
  import rv32_store_align_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr, req_data;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign_valid;
  logic [31:0] misalign_addr;
  logic [$clog2(DEPTH):0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_store_align #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .misalign_valid(misalign_valid), .misalign_addr(misalign_addr), .count(count)
  );

  // Waits (bounded) for req_ready, presents one request for one cycle, returns on the following negedge.
  task automatic push(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    n_tests++;
    if (!req_ready) begin n_fail++; $display("FAIL push_timeout addr=%h req_ready stayed 0", a); end
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 1'b0; req_op = MEM_NONE; req_addr = '0; req_data = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got %b exp 0", mem_valid); end
    n_tests++; if (misalign_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mis_valid got %b exp 0", misalign_valid); end
    n_tests++; if (misalign_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mis_addr got %h exp 0", misalign_addr); end
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_fail++; $display("FAIL rst_head got %h/%h/%b exp zeros", mem_addr, mem_wdata, mem_wstrb); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_aligned;
    mem_op_t     ops [6] = '{MEM_SB, MEM_SH, MEM_SW, MEM_SB, MEM_SB, MEM_SH};
    logic [31:0] adr [6] = '{32'h0000_1003, 32'h0000_2002, 32'h0000_4000, 32'h0000_5001, 32'h0000_6006, 32'h0000_7000};
    logic [31:0] dat [6] = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_00CD, 32'h1234_56EF, 32'hCAFE_BEEF};
    logic [31:0] ea  [6] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_4000, 32'h0000_5000, 32'h0000_6004, 32'h0000_7000};
    logic [31:0] ed  [6] = '{32'hAB00_0000, 32'h1234_0000, 32'hDEAD_BEEF, 32'h0000_CD00, 32'h56EF_0000, 32'hCAFE_BEEF};
    logic [3:0]  es  [6] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0100, 4'b0011};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(ops[i], adr[i], dat[i]);
      n_tests++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL al%0d_valid got %b exp 1", i, mem_valid); end
      n_tests++; if (mem_addr !== ea[i]) begin n_fail++; $display("FAIL al%0d_addr got %h exp %h", i, mem_addr, ea[i]); end
      n_tests++; if (mem_wdata !== ed[i]) begin n_fail++; $display("FAIL al%0d_wdata got %h exp %h", i, mem_wdata, ed[i]); end
      n_tests++; if (mem_wstrb !== es[i]) begin n_fail++; $display("FAIL al%0d_wstrb got %b exp %b", i, mem_wstrb, es[i]); end
      @(negedge clk);
      n_tests++; if (count !== 2'd0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL al%0d_drain count=%0d valid=%b exp 0/0", i, count, mem_valid); end
    end
  endtask

`ifdef RV32_STORE_SPLIT_EN
  task automatic test_split;
    mem_ready = 1'b0;
    push(MEM_SW, 32'h0000_3001, 32'h1122_3344);
    n_tests++; if (count !== 2'd2 || req_ready !== 1'b0) begin n_fail++; $display("FAIL sp_full count=%0d ready=%b exp 2/0", count, req_ready); end
    n_tests++; if (misalign_valid !== 1'b0) begin n_fail++; $display("FAIL sp_nofault got %b exp 0", misalign_valid); end
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_3000, 32'h2233_4400, 4'b1110}) begin n_fail++; $display("FAIL sp_b0 got %h/%h/%b exp 00003000/22334400/1110", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_3004, 32'h0000_0011, 4'b0001}) begin n_fail++; $display("FAIL sp_b1 got %h/%h/%b exp 00003004/00000011/0001", mem_addr, mem_wdata, mem_wstrb); end
    @(negedge clk);
    n_tests++; if (count !== 2'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL sp_drain count=%0d ready=%b exp 0/1", count, req_ready); end
    mem_ready = 1'b0;
    push(MEM_SH, 32'hFFFF_FFFF, 32'h0000_BEEF);
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000}) begin n_fail++; $display("FAIL spw_b0 got %h/%h/%b exp fffffffc/ef000000/1000", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_0000, 32'h0000_00BE, 4'b0001}) begin n_fail++; $display("FAIL spw_b1 got %h/%h/%b exp 00000000/000000be/0001", mem_addr, mem_wdata, mem_wstrb); end
    @(negedge clk);
    mem_ready = 1'b0;
    push(MEM_SH, 32'h0000_6001, 32'h0000_BEEF);
    n_tests++; if (count !== 2'd1) begin n_fail++; $display("FAIL sh1_count got %0d exp 1", count); end
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_6000, 32'h00BE_EF00, 4'b0110}) begin n_fail++; $display("FAIL sh1_beat got %h/%h/%b exp 00006000/00beef00/0110", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    @(negedge clk);
  endtask
`else
  task automatic test_misalign;
    mem_ready = 1'b1;
    push(MEM_SW, 32'h0000_3001, 32'h1122_3344);
    n_tests++; if (misalign_valid !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got %b exp 1", misalign_valid); end
    n_tests++; if (misalign_addr !== 32'h0000_3001) begin n_fail++; $display("FAIL mis_addr got %h exp 00003001", misalign_addr); end
    n_tests++; if (mem_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL mis_nopush valid=%b count=%0d exp 0/0", mem_valid, count); end
    @(negedge clk);
    n_tests++; if (misalign_valid !== 1'b0) begin n_fail++; $display("FAIL mis_oneshot got %b exp 0", misalign_valid); end
    n_tests++; if (misalign_addr !== 32'h0000_3001) begin n_fail++; $display("FAIL mis_hold got %h exp 00003001", misalign_addr); end
    push(MEM_SH, 32'h0000_6001, 32'h0000_BEEF);
    n_tests++; if (misalign_valid !== 1'b1 || misalign_addr !== 32'h0000_6001) begin n_fail++; $display("FAIL mis_sh got %b/%h exp 1/00006001", misalign_valid, misalign_addr); end
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mis_sh_nopush got %b exp 0", mem_valid); end
    @(negedge clk);
  endtask

  task automatic test_full;
    mem_ready = 1'b0;
    push(MEM_SW, 32'h0000_A000, 32'h0101_0101);
    push(MEM_SW, 32'h0000_A004, 32'h0202_0202);
    n_tests++; if (count !== 2'd2 || req_ready !== 1'b0) begin n_fail++; $display("FAIL full_count count=%0d ready=%b exp 2/0", count, req_ready); end
    repeat (2) begin
      n_tests++; if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_A000, 32'h0101_0101, 4'b1111}) begin n_fail++; $display("FAIL full_hold got %b/%h/%h/%b exp 1/0000a000/01010101/1111", mem_valid, mem_addr, mem_wdata, mem_wstrb); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({mem_addr, mem_wdata} !== {32'h0000_A004, 32'h0202_0202}) begin n_fail++; $display("FAIL full_order got %h/%h exp 0000a004/02020202", mem_addr, mem_wdata); end
    n_tests++; if (count !== 2'd1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL full_credit count=%0d ready=%b exp 1/1", count, req_ready); end
    @(negedge clk);
    n_tests++; if (count !== 2'd0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty count=%0d valid=%b exp 0/0", count, mem_valid); end
  endtask
`endif

  task automatic test_nonstore;
    mem_ready = 1'b1;
    push(MEM_LW, 32'h0000_8001, 32'h0000_0055);
    n_tests++; if (mem_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL ns_nopush valid=%b count=%0d exp 0/0", mem_valid, count); end
    n_tests++; if (misalign_valid !== 1'b0) begin n_fail++; $display("FAIL ns_nofault got %b exp 0", misalign_valid); end
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b0;
`ifdef RV32_STORE_SPLIT_EN
    push(MEM_SW, 32'h0000_B001, 32'h1111_1111);
`else
    push(MEM_SW, 32'h0000_B000, 32'h1111_1111);
    push(MEM_SW, 32'h0000_B004, 32'h2222_2222);
`endif
    n_tests++; if (count !== 2'd2) begin n_fail++; $display("FAIL rm_pre count got %0d exp 2", count); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mem_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL rm_async valid=%b count=%0d exp 0/0", mem_valid, count); end
    n_tests++; if (mem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL rm_wstrb got %b exp 0000", mem_wstrb); end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    push(MEM_SB, 32'h0000_C002, 32'h0000_0077);
    n_tests++; if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_C000, 32'h0077_0000, 4'b0100}) begin n_fail++; $display("FAIL rm_new got %b/%h/%h/%b exp 1/0000c000/00770000/0100", mem_valid, mem_addr, mem_wdata, mem_wstrb); end
    @(negedge clk);
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL rm_drain count got %0d exp 0", count); end
  endtask

  initial begin
    req_valid = 1'b0; req_op = MEM_NONE; req_addr = '0; req_data = '0; mem_ready = 1'b0;
    test_reset;
    test_aligned;
`ifdef RV32_STORE_SPLIT_EN
    test_split;
`else
    test_misalign;
    test_full;
`endif
    test_nonstore;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_store_align.md
Name: rv32_store_align

Overview:
- Store-side counterpart of the writeback load-fix path.
- Takes a raw store request from the memory stage: op, byte address and rs2 data.
- Produces a word-aligned data-memory write: aligned address, lane-shifted write data and 4-bit byte strobes.
- Formatted writes are buffered in a small in-order FIFO with valid/ready handshakes on both sides. Misaligned stores raise a fault.

Parameters:
- DEPTH, 2: FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request valid
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_op  in  mem_op_t  MEM_SB / MEM_SH / MEM_SW; any other value is a non-store
- req_addr  in  32  byte address
- req_data  in  32  store data, right-justified
- mem_valid  out  1  FIFO head valid
- mem_ready  in  1  memory accepts head beat
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-positioned write data
- mem_wstrb  out  4  byte enables, bit i selects wdata[8i+7:8i]
- misalign_valid  out  1  one-cycle fault pulse
- misalign_addr  out  32  faulting byte address, held until the next fault
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, active-high): FIFO emptied, count=0, mem_valid=0, misalign_valid=0, misalign_addr=0. mem_addr/wdata/wstrb read 0 while empty.
- Size mask: SB=4'b0001, SH=4'b0011, SW=4'b1111. Offset o = req_addr[1:0].
- Aligned cases: SB at any o; SH at o in {0,2}; SW at o=0.
- Aligned formatting: mem_addr = {req_addr[31:2],2'b00}, wdata = req_data << 8*o, wstrb = mask << o.
  - Unused lanes carry shifted data and are masked by wstrb, not zeroed.
- Handshake and latency:
  - A write accepted in cycle N appears at the FIFO head with mem_valid=1 no earlier than cycle N+1. There is no bypass.
  - Head pops on mem_valid && mem_ready.
  - Order is strictly preserved.
- req_ready is computed from registered count only; a same-cycle pop gives no credit.
  - Feature off: req_ready = (count <= DEPTH-1).
  - Feature on: req_ready = (count <= DEPTH-2).
- Simultaneous push and pop: count unchanged, head advances, new entry goes to the tail.
- Misaligned SH or SW with feature off:
  - Request is accepted and nothing is pushed.
  - misalign_valid=1 in cycle N+1 for exactly one cycle.
  - misalign_addr is registered to req_addr.
- Non-store op: accepted and dropped. No push, no fault.
- Full (count==DEPTH): mem_valid stays 1; held head outputs stay stable while mem_ready=0.
- Reset mid-operation: all queued beats are discarded immediately. No partial split beat survives.

Optional Feature:
- Macro: RV32_STORE_SPLIT_EN.
- Defined: a misaligned SH/SW is split into two aligned beats pushed in the same cycle, beat0 before beat1.
  - beat0: addr = {req_addr[31:2],2'b00}, wdata = req_data << 8*o, wstrb = (mask << o) & 4'hF.
  - beat1: addr = beat0 addr + 4 (wraps 0xFFFFFFFC -> 0x00000000), wdata = req_data >> 8*(4-o), wstrb = mask >> (4-o).
  - An SH at o=1 is not split; it is a single beat with wstrb=4'b0110.
  - Split only occurs when the access crosses a word boundary.
  - misalign_valid is never asserted.
- Undefined: fault behaviour as above; misaligned stores are never written.

Test Plan:
- SB, addr 0x00001003, data 0x000000AB, mem_ready=1 -> next cycle: mem_addr 0x00001000, wdata 0xAB000000, wstrb 4'b1000; count returns to 0.
- SH, addr 0x00002002, data 0x00001234 -> mem_addr 0x00002000, wdata 0x12340000, wstrb 4'b1100.
- SW, addr 0x00003001, data 0x11223344, feature off -> no mem_valid; misalign_valid pulses once, misalign_addr 0x00003001.
- Same SW with RV32_STORE_SPLIT_EN -> beat0 (0x00003000, 0x22334400, 4'b1110), then beat1 (0x00003004, 0x00000011, 4'b0001); SH at 0xFFFFFFFF splits with beat1 addr 0x00000000, wstrb 4'b0001.
- mem_ready=0 while pushing DEPTH aligned SWs -> count=DEPTH, req_ready=0, head outputs stable; raise mem_ready -> entries drain in push order, one per cycle, req_ready returns 1.
- Assert rst with 2 entries queued and mem_ready=0 -> mem_valid=0 and count=0 with no clock edge; after deassert the first new request drains normally.
